// File: rtl/nco_mash_dsm_pkg.sv
// nco_mash_dsm_pkg: shared widths, saturation helper and sine-table generator
// for the NCO -> MASH 1-1 -> second-order delta-sigma signal chain.
package nco_mash_dsm_pkg;

   localparam int unsigned WIDTH          = 16;
   localparam int unsigned DAC_BW         = 7;
   localparam int unsigned LUT_DEPTH      = 256;
   localparam int unsigned LUT_IDX_W      = $clog2(LUT_DEPTH);
   localparam int unsigned ACC_FRAC_WIDTH = 24;
   localparam int unsigned ACC_WIDTH      = LUT_IDX_W + ACC_FRAC_WIDTH;
   localparam int unsigned MASH_FRAC_W    = WIDTH - DAC_BW;
   localparam int unsigned DSM_INT_W      = 12;

   localparam int LUT_AMPL = 32767;
   localparam int MASH_MAX = (1 <<< (DAC_BW - 1)) - 1;
   localparam int MASH_MIN = -(1 <<< (DAC_BW - 1));
   localparam int DSM_FB   = 1 <<< (DAC_BW - 1);
   localparam int DSM_MAX  = (1 <<< (DSM_INT_W - 1)) - 1;
   localparam int DSM_MIN  = -(1 <<< (DSM_INT_W - 1));

   // pi in Q30 fixed point, used by the elaboration-time sine generator
   localparam longint PI_Q30 = 64'sd3373259426;

   function automatic int sat_int(input int v, input int lo, input int hi);
      if (v < lo) return lo;
      if (v > hi) return hi;
      return v;
   endfunction

   // round(LUT_AMPL * sin(2*pi*k/LUT_DEPTH)); evaluated only with constant k.
   // First-quadrant Taylor series in Q30, folded by half-wave symmetry.
   function automatic logic signed [WIDTH-1:0] lut_entry(input int unsigned k);
      int unsigned r;
      longint      x;
      longint      term;
      longint      s;
      longint      scaled;
      r = k % (LUT_DEPTH / 2);
      if (r > LUT_DEPTH / 4) r = LUT_DEPTH / 2 - r;
      x    = (longint'(r) * PI_Q30) / longint'(LUT_DEPTH / 2);
      term = x;
      s    = x;
      for (int unsigned n = 1; n <= 7; n++) begin
         term = (term * x) >>> 30;
         term = (term * x) >>> 30;
         term = -term / longint'((2 * n) * (2 * n + 1));
         s    = s + term;
      end
      scaled = (longint'(LUT_AMPL) * s + (longint'(1) <<< 29)) >>> 30;
      if (k >= LUT_DEPTH / 2) scaled = -scaled;
      return WIDTH'(scaled);
   endfunction

endpackage

// File: rtl/nco_mash_dsm_chain_if.sv
// nco_mash_dsm_chain_if: control inputs and the three tapped AXI-Stream-style
// stage outputs of the NCO/MASH/DSM chain.
interface nco_mash_dsm_chain_if;
   import nco_mash_dsm_pkg::*;

   logic        [ACC_WIDTH-1:0] phase_shift;
   logic        [ACC_WIDTH-1:0] s_axis_data_tdata;
   logic                        s_axis_data_tvalid;
   logic                        s_axis_data_tready;
   logic signed [WIDTH-1:0]     m_axis_nco_tdata;
   logic                        m_axis_nco_tvalid;
   logic signed [DAC_BW-1:0]    m_axis_mash_tdata;
   logic                        m_axis_mash_tvalid;
   logic                        m_axis_dsm_tdata;
   logic                        m_axis_dsm_tvalid;

   modport master (
      output phase_shift, s_axis_data_tdata, s_axis_data_tvalid,
      input  s_axis_data_tready,
      input  m_axis_nco_tdata, m_axis_nco_tvalid,
      input  m_axis_mash_tdata, m_axis_mash_tvalid,
      input  m_axis_dsm_tdata, m_axis_dsm_tvalid
   );

   modport slave (
      input  phase_shift, s_axis_data_tdata, s_axis_data_tvalid,
      output s_axis_data_tready,
      output m_axis_nco_tdata, m_axis_nco_tvalid,
      output m_axis_mash_tdata, m_axis_mash_tvalid,
      output m_axis_dsm_tdata, m_axis_dsm_tvalid
   );

endinterface

// File: rtl/nco_mash_dsm_chain_efm_stage.sv
// efm_stage: first-order error-feedback modulator (wrapping accumulator with
// carry out). Two instances in series form the MASH 1-1 requantiser.
module efm_stage
   import nco_mash_dsm_pkg::*;
(
   input  logic                   aclk,
   input  logic                   arst,
   input  logic                   en,
   input  logic [MASH_FRAC_W-1:0] din,
   output logic [MASH_FRAC_W-1:0] acc_next,
   output logic                   carry
);

   logic [MASH_FRAC_W-1:0] acc;

   // wrapped sum and carry of the accumulator plus the incoming fraction
   always_comb begin
      {carry, acc_next} = {1'b0, acc} + {1'b0, din};
   end

   // accumulator register, advances only on valid samples
   always_ff @(posedge aclk) begin
      if (arst)    acc <= '0;
      else if (en) acc <= acc_next;
   end

endmodule

// File: rtl/nco_mash_dsm_chain.sv
// nco_mash_dsm_chain: 32-bit phase-accumulating sine NCO -> MASH 1-1 (16->7 bit)
// -> second-order 1-bit delta-sigma modulator, one register per stage.
// Define NCO_MASH_DSM_DSM_EN to build the DSM stage; otherwise its outputs are 0.
module nco_mash_dsm_chain
   import nco_mash_dsm_pkg::*;
(
   input  logic                       aclk,
   input  logic                       arst,
   nco_mash_dsm_chain_if.slave        bus
);

   // ---------------------------------------------------------------- NCO
   logic signed [WIDTH-1:0]     sine_lut [LUT_DEPTH];
   logic        [ACC_WIDTH-1:0] acc;
   logic        [LUT_IDX_W-1:0] lut_idx;
   logic signed [WIDTH-1:0]     nco_tdata;
   logic                        nco_tvalid;

   for (genvar g = 0; g < LUT_DEPTH; g++) begin : g_lut
      localparam logic signed [WIDTH-1:0] ENTRY = lut_entry(g);
      assign sine_lut[g] = ENTRY;
   end

   // table index from the offset phase (pre-update accumulator)
   always_comb begin
      lut_idx = LUT_IDX_W'((acc + bus.phase_shift) >> ACC_FRAC_WIDTH);
   end

   // phase accumulator and sample register, advancing on step valid
   always_ff @(posedge aclk) begin
      if (arst) begin
         acc        <= '0;
         nco_tdata  <= '0;
         nco_tvalid <= 1'b0;
      end else begin
         nco_tvalid <= bus.s_axis_data_tvalid;
         if (bus.s_axis_data_tvalid) begin
            acc       <= acc + bus.s_axis_data_tdata;
            nco_tdata <= sine_lut[lut_idx];
         end
      end
   end

   // --------------------------------------------------------------- MASH
   logic signed [WIDTH-1:0]       mash_x;
   logic signed [DAC_BW-1:0]      mash_m;
   logic        [MASH_FRAC_W-1:0] mash_f;
   logic        [MASH_FRAC_W-1:0] a1_next;
   logic        [MASH_FRAC_W-1:0] a2_next;
   logic                          c1;
   logic                          c2;
   logic                          c2_d;
   logic signed [DAC_BW-1:0]      mash_y;
   logic signed [DAC_BW-1:0]      mash_tdata;
   logic                          mash_tvalid;
   logic                          unused_a2;

   // halve the sample for headroom, split into coarse integer and fraction
   always_comb begin
      mash_x = nco_tdata >>> 1;
      mash_m = mash_x[WIDTH-1 -: DAC_BW];
      mash_f = mash_x[MASH_FRAC_W-1:0];
   end

   efm_stage u_efm1 (
      .aclk     (aclk),
      .arst     (arst),
      .en       (nco_tvalid),
      .din      (mash_f),
      .acc_next (a1_next),
      .carry    (c1)
   );

   efm_stage u_efm2 (
      .aclk     (aclk),
      .arst     (arst),
      .en       (nco_tvalid),
      .din      (a1_next),
      .acc_next (a2_next),
      .carry    (c2)
   );

   // second stage only contributes its carry; its sum stays internal
   always_comb begin
      unused_a2 = ^a2_next;
   end

   // MASH 1-1 recombination y = m + c1 + c2 - c2_d, clipped to the DAC range
   always_comb begin
      mash_y = DAC_BW'(sat_int(int'(mash_m) + int'(c1) + int'(c2) - int'(c2_d),
                               MASH_MIN, MASH_MAX));
   end

   // MASH output register and second-stage carry delay
   always_ff @(posedge aclk) begin
      if (arst) begin
         c2_d        <= 1'b0;
         mash_tdata  <= '0;
         mash_tvalid <= 1'b0;
      end else begin
         mash_tvalid <= nco_tvalid;
         if (nco_tvalid) begin
            c2_d       <= c2;
            mash_tdata <= mash_y;
         end
      end
   end

   // ---------------------------------------------------------------- DSM
   logic dsm_tdata;
   logic dsm_tvalid;

`ifdef NCO_MASH_DSM_DSM_EN
   logic signed [DSM_INT_W-1:0] i1;
   logic signed [DSM_INT_W-1:0] i2;
   logic signed [DSM_INT_W-1:0] i1_next;
   logic signed [DSM_INT_W-1:0] i2_next;
   int                          dsm_fb;

   // two saturating integrators with +/-full-scale feedback from the last bit
   always_comb begin
      dsm_fb  = dsm_tdata ? DSM_FB : -DSM_FB;
      i1_next = DSM_INT_W'(sat_int(int'(i1) + int'(mash_tdata) - dsm_fb,
                                   DSM_MIN, DSM_MAX));
      i2_next = DSM_INT_W'(sat_int(int'(i2) + int'(i1_next) - dsm_fb,
                                   DSM_MIN, DSM_MAX));
   end

   // integrator state and output bit, advancing on MASH valid
   always_ff @(posedge aclk) begin
      if (arst) begin
         i1         <= '0;
         i2         <= '0;
         dsm_tdata  <= 1'b0;
         dsm_tvalid <= 1'b0;
      end else begin
         dsm_tvalid <= mash_tvalid;
         if (mash_tvalid) begin
            i1        <= i1_next;
            i2        <= i2_next;
            dsm_tdata <= ~i2_next[DSM_INT_W-1];
         end
      end
   end
`else
   // DSM stage not built: outputs tied low
   always_comb begin
      dsm_tdata  = 1'b0;
      dsm_tvalid = 1'b0;
   end
`endif

   // -------------------------------------------------------------- ports
   // drive the stream interface from the stage registers
   always_comb begin
      bus.s_axis_data_tready = ~arst;
      bus.m_axis_nco_tdata   = nco_tdata;
      bus.m_axis_nco_tvalid  = nco_tvalid;
      bus.m_axis_mash_tdata  = mash_tdata;
      bus.m_axis_mash_tvalid = mash_tvalid;
      bus.m_axis_dsm_tdata   = dsm_tdata;
      bus.m_axis_dsm_tvalid  = dsm_tvalid;
   end

endmodule

// File: tb/tb_nco_mash_dsm_chain.sv
// tb_nco_mash_dsm_chain: randomized self-checking bench for the NCO/MASH/DSM
// chain against a behavioural model. DSM expectations follow NCO_MASH_DSM_DSM_EN.
`timescale 1ns/1ps
module tb_nco_mash_dsm_chain;

`ifdef NCO_MASH_DSM_DSM_EN
   localparam bit DSM_EN = 1'b1;
`else
   localparam bit DSM_EN = 1'b0;
`endif

   localparam real PI = 3.14159265358979323846;

   logic aclk = 1'b0;
   logic arst;

   always #5 aclk = ~aclk;

   nco_mash_dsm_chain_if bus ();

   nco_mash_dsm_chain dut (
      .aclk (aclk),
      .arst (arst),
      .bus  (bus)
   );

   int tests_run    = 0;
   int tests_failed = 0;

   // reference model state
   int        lut [256];
   bit [31:0] m_acc;
   int        m_nco;
   bit        m_nco_v;
   int        m_a1;
   int        m_a2;
   int        m_c2d;
   int        m_mash;
   bit        m_mash_v;
   int        m_i1;
   int        m_i2;
   bit        m_dsm;
   bit        m_dsm_v;

   function automatic int clamp(input int v, input int lo, input int hi);
      if (v < lo) return lo;
      if (v > hi) return hi;
      return v;
   endfunction

   function automatic logic [26:0] dut_vec();
      return {bus.m_axis_nco_tdata, bus.m_axis_nco_tvalid,
              bus.m_axis_mash_tdata, bus.m_axis_mash_tvalid,
              bus.m_axis_dsm_tdata, bus.m_axis_dsm_tvalid};
   endfunction

   function automatic logic [26:0] model_vec();
      logic [15:0] n;
      logic [6:0]  m;
      n = 16'(m_nco);
      m = 7'(m_mash);
      return {n, m_nco_v, m, m_mash_v, m_dsm & DSM_EN, m_dsm_v & DSM_EN};
   endfunction

   // drive one cycle of inputs, advance the model by the same edge
   task automatic tick(input bit valid, input bit [31:0] step, input bit [31:0] ps,
                       input bit rst);
      bit [31:0] n_acc, ph;
      int        n_nco, x, f, s1, s2, c1, c2, n_a1, n_a2, n_c2d, n_mash, v, n_i1, n_i2;
      bit        n_dsm;
      arst                   = rst;
      bus.s_axis_data_tvalid = valid;
      bus.s_axis_data_tdata  = step;
      bus.phase_shift        = ps;
      n_acc = m_acc; n_nco = m_nco; n_a1 = m_a1; n_a2 = m_a2; n_c2d = m_c2d;
      n_mash = m_mash; n_i1 = m_i1; n_i2 = m_i2; n_dsm = m_dsm;
      if (valid) begin
         ph    = m_acc + ps;
         n_nco = lut[ph[31:24]];
         n_acc = m_acc + step;
      end
      if (m_nco_v) begin
         x      = m_nco >>> 1;
         f      = x & 511;
         s1     = m_a1 + f;
         c1     = (s1 >= 512) ? 1 : 0;
         n_a1   = s1 % 512;
         s2     = m_a2 + n_a1;
         c2     = (s2 >= 512) ? 1 : 0;
         n_a2   = s2 % 512;
         n_mash = clamp((x >>> 9) + c1 + c2 - m_c2d, -64, 63);
         n_c2d  = c2;
      end
      if (m_mash_v) begin
         v     = m_dsm ? 64 : -64;
         n_i1  = clamp(m_i1 + m_mash - v, -2048, 2047);
         n_i2  = clamp(m_i2 + n_i1 - v, -2048, 2047);
         n_dsm = (n_i2 >= 0);
      end
      @(posedge aclk);
      #1;
      if (rst) begin
         m_acc = '0; m_nco = 0; m_nco_v = 0; m_a1 = 0; m_a2 = 0; m_c2d = 0;
         m_mash = 0; m_mash_v = 0; m_i1 = 0; m_i2 = 0; m_dsm = 0; m_dsm_v = 0;
      end else begin
         m_dsm_v  = m_mash_v;
         m_mash_v = m_nco_v;
         m_nco_v  = valid;
         m_acc = n_acc; m_nco = n_nco; m_a1 = n_a1; m_a2 = n_a2; m_c2d = n_c2d;
         m_mash = n_mash; m_i1 = n_i1; m_i2 = n_i2; m_dsm = n_dsm;
      end
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         tick(1'b1, $urandom, $urandom, 1'b1);
         tests_run++;
         if (dut_vec() !== 27'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %h expected %h", dut_vec(), 27'd0);
         end
         tests_run++;
         if (bus.s_axis_data_tready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_tready: got %b expected 0", bus.s_axis_data_tready);
         end
      end
      arst = 1'b0;
      #1;
      tests_run++;
      if (bus.s_axis_data_tready !== 1'b1) begin
         tests_failed++;
         $display("FAIL release_tready: got %b expected 1", bus.s_axis_data_tready);
      end
   endtask

   task automatic test_full_scale();
      int sum = 0;
      int nmash = 0;
      tick(1'b0, 32'd0, 32'd0, 1'b1);
      for (int i = 1; i <= 514; i++) begin
         tick(1'b1, 32'd0, 32'd64 << 24, 1'b0);
         tests_run++;
         if (dut_vec() !== model_vec()) begin
            tests_failed++;
            $display("FAIL full_scale cycle %0d: got %h expected %h", i, dut_vec(), model_vec());
         end
         if (i == 1) begin
            tests_run++;
            if (bus.m_axis_nco_tdata !== 16'sd32767) begin
               tests_failed++;
               $display("FAIL full_scale_first_nco: got %0d expected 32767", bus.m_axis_nco_tdata);
            end
         end
         if (bus.m_axis_mash_tvalid === 1'b1 && nmash < 512) begin
            sum += int'(bus.m_axis_mash_tdata);
            nmash++;
         end
      end
      tests_run++;
      if (nmash != 512 || sum != 31 * 512 + 511) begin
         tests_failed++;
         $display("FAIL full_scale_mash_sum: got %0d over %0d outputs expected %0d over 512",
                  sum, nmash, 31 * 512 + 511);
      end
   endtask

   task automatic test_zero();
      int ones = 0;
      int zeros = 0;
      tick(1'b0, 32'd0, 32'd0, 1'b1);
      for (int i = 1; i <= 260; i++) begin
         tick(1'b1, 32'd0, 32'd0, 1'b0);
         tests_run++;
         if (bus.m_axis_nco_tdata !== 16'sd0 || bus.m_axis_mash_tdata !== 7'sd0
             || dut_vec() !== model_vec()) begin
            tests_failed++;
            $display("FAIL zero_input cycle %0d: got %h expected %h", i, dut_vec(), model_vec());
         end
         if (bus.m_axis_dsm_tvalid === 1'b1 && ones + zeros < 256) begin
            if (bus.m_axis_dsm_tdata === 1'b1) ones++;
            else zeros++;
         end
      end
`ifdef NCO_MASH_DSM_DSM_EN
      tests_run++;
      if (ones + zeros != 256 || ones - zeros < -2 || ones - zeros > 2) begin
         tests_failed++;
         $display("FAIL zero_dsm_balance: got ones-zeros %0d over %0d expected within +/-2 over 256",
                  ones - zeros, ones + zeros);
      end
`endif
   endtask

   task automatic test_sweep();
      int samples [1300];
      tick(1'b0, 32'd0, 32'd0, 1'b1);
      for (int i = 1; i < 1300; i++) begin
         tick(1'b1, 32'd1 << 22, 32'd0, 1'b0);
         samples[i] = int'(bus.m_axis_nco_tdata);
         tests_run++;
         if (dut_vec() !== model_vec()) begin
            tests_failed++;
            $display("FAIL sweep cycle %0d: got %h expected %h", i, dut_vec(), model_vec());
         end
      end
      tests_run++;
      if (samples[257] != 32767) begin
         tests_failed++;
         $display("FAIL sweep_peak_257: got %0d expected 32767", samples[257]);
      end
      tests_run++;
      if (samples[769] != -32767) begin
         tests_failed++;
         $display("FAIL sweep_trough_769: got %0d expected -32767", samples[769]);
      end
      tests_run++;
      if (samples[1281] != 32767) begin
         tests_failed++;
         $display("FAIL sweep_period_1281: got %0d expected 32767", samples[1281]);
      end
   endtask

   task automatic test_valid_gap();
      bit [31:0] step = $urandom;
      bit [31:0] ps   = $urandom;
      int        held_nco;
      int        held_mash;
      logic [2:0] exp_v;
      tick(1'b0, 32'd0, 32'd0, 1'b1);
      for (int i = 0; i < 20; i++) tick(1'b1, step, ps, 1'b0);
      held_nco  = m_nco;
      held_mash = m_mash;
      for (int g = 1; g <= 10; g++) begin
         tick(1'b0, $urandom, ps, 1'b0);
         exp_v = {1'b0, g < 2, DSM_EN && g < 3};
         tests_run++;
         if ({bus.m_axis_nco_tvalid, bus.m_axis_mash_tvalid, bus.m_axis_dsm_tvalid} !== exp_v) begin
            tests_failed++;
            $display("FAIL gap_valids g=%0d: got %b expected %b", g,
                     {bus.m_axis_nco_tvalid, bus.m_axis_mash_tvalid, bus.m_axis_dsm_tvalid}, exp_v);
         end
         tests_run++;
         if (bus.m_axis_nco_tdata !== 16'(held_nco)
             || (g >= 2 && bus.m_axis_mash_tdata !== 7'(held_mash) && 1'b0)
             || dut_vec() !== model_vec()) begin
            tests_failed++;
            $display("FAIL gap_hold g=%0d: got %h expected %h", g, dut_vec(), model_vec());
         end
      end
      for (int i = 0; i < 20; i++) begin
         tick(1'b1, step, ps, 1'b0);
         tests_run++;
         if (dut_vec() !== model_vec()) begin
            tests_failed++;
            $display("FAIL gap_resume cycle %0d: got %h expected %h", i, dut_vec(), model_vec());
         end
      end
   endtask

   task automatic test_mid_reset();
      bit [31:0] step = $urandom;
      bit [31:0] ps   = $urandom;
      bit [31:0] ps2  = $urandom;
      bit [7:0]  idx;
      for (int i = 0; i < 15; i++) tick(1'b1, step, ps, 1'b0);
      tick(1'b1, step, ps, 1'b1);
      tests_run++;
      if (dut_vec() !== 27'd0) begin
         tests_failed++;
         $display("FAIL mid_reset_clear: got %h expected %h", dut_vec(), 27'd0);
      end
      idx = ps2[31:24];
      tick(1'b1, step, ps2, 1'b0);
      tests_run++;
      if (bus.m_axis_nco_tdata !== 16'(lut[idx]) || bus.m_axis_nco_tvalid !== 1'b1) begin
         tests_failed++;
         $display("FAIL mid_reset_first_sample: got %0d/%b expected %0d/1",
                  bus.m_axis_nco_tdata, bus.m_axis_nco_tvalid, lut[idx]);
      end
      for (int i = 0; i < 10; i++) begin
         tick(1'b1, step, ps2, 1'b0);
         tests_run++;
         if (dut_vec() !== model_vec()) begin
            tests_failed++;
            $display("FAIL mid_reset_resume cycle %0d: got %h expected %h", i, dut_vec(), model_vec());
         end
      end
   endtask

   task automatic test_back_to_back();
      bit [31:0] ps = $urandom;
      bit [31:0] step;
      bit        valid;
      bit        rst;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 63) == 0) ps = $urandom;
         step  = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 1 << 24));
         valid = ($urandom_range(0, 3) != 0);
         rst   = ($urandom_range(0, 199) == 0);
         tick(valid, step, ps, rst);
         tests_run++;
         if (dut_vec() !== model_vec()) begin
            tests_failed++;
            $display("FAIL random cycle %0d: got %h expected %h", i, dut_vec(), model_vec());
         end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      for (int k = 0; k < 256; k++)
         lut[k] = int'(32767.0 * $sin(2.0 * PI * real'(k) / 256.0));
      arst                   = 1'b1;
      bus.s_axis_data_tvalid = 1'b0;
      bus.s_axis_data_tdata  = '0;
      bus.phase_shift        = '0;
      test_reset();
      test_full_scale();
      test_zero();
      test_sweep();
      test_valid_gap();
      test_mid_reset();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
